// File: rtl/bk_pkg.sv
// Shared Brent-Kung prefix types and the group generate/propagate combine operator.
package bk_pkg;

  localparam int unsigned BK_WIDTH  = 12;
  localparam int unsigned BK_LEVELS = $clog2(BK_WIDTH + 2);

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  function automatic pg_t bk_pg(input logic g_hi, input logic p_hi,
                                input logic g_lo, input logic p_lo);
    pg_t r;
    r.g = g_hi | (p_hi & g_lo);
    r.p = p_hi & p_lo;
    return r;
  endfunction

  function automatic int unsigned bk_levels(input int unsigned w);
    return $clog2(w + 2);
  endfunction

endpackage

// File: rtl/bk_pipe_stage.sv
// One valid/ready register slice; loads when empty or when its contents leave this cycle.
module bk_pipe_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign ready_o = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (ready_o) begin
      valid_q <= valid_i;
      if (valid_i) data_q <= data_i;
    end
  end

endmodule

// File: rtl/brent_kung_sub_pipe.sv
// Recovers B = S - A through a 3-stage Brent-Kung prefix pipeline with valid/ready on both sides.
module brent_kung_sub_pipe
  import bk_pkg::*;
#(
  parameter int unsigned WIDTH = BK_WIDTH,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   in_sum,
  input  logic [WIDTH-1:0] in_a,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_b,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned W2     = WIDTH + 2;
  localparam int unsigned LEVELS = (WIDTH == BK_WIDTH) ? BK_LEVELS : bk_levels(WIDTH);

  typedef struct packed {
    logic [W2-1:0]    g;
    logic [W2-1:0]    p;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic [W2-1:0]    gg;
    logic [W2-1:0]    pp;
    logic [W2-1:0]    p;
    logic [TAG_W-1:0] tag;
  } s2_t;

  typedef struct packed {
    logic [WIDTH-1:0] b;
    logic             err;
    logic [TAG_W-1:0] tag;
  } s3_t;

  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  s3_t  s3_d, s3_q;
  logic v1, v2, r2, r3;

  // The +1 carry-in is absorbed into bit 0's generate so the prefix tree needs no cin term.
  always_comb begin
    logic [W2-1:0] x, y;
    x        = {2'b00, in_sum};
    y        = {2'b11, ~in_a};
    s1_d     = '0;
    s1_d.g   = x & y;
    s1_d.p   = x ^ y;
    s1_d.g[0] = x[0] | y[0];
    s1_d.tag = in_tag;
  end

  always_comb begin
    pg_t t [W2];
    for (int unsigned i = 0; i < W2; i++) t[i] = '{g: s1_q.g[i], p: s1_q.p[i]};
    for (int unsigned l = 0; l < LEVELS; l++)
      for (int unsigned i = 0; i < W2; i++)
        if (((i + 1) % (2 << l)) == 0)
          t[i] = bk_pg(t[i].g, t[i].p, t[i - (1 << l)].g, t[i - (1 << l)].p);
    s2_d     = '0;
    s2_d.p   = s1_q.p;
    s2_d.tag = s1_q.tag;
    for (int unsigned i = 0; i < W2; i++) begin
      s2_d.gg[i] = t[i].g;
      s2_d.pp[i] = t[i].p;
    end
  end

  // Down-sweep fills the odd-span positions from the largest group downwards.
  always_comb begin
    pg_t           t [W2];
    int unsigned   l;
    logic [W2-1:0] c, d;
    for (int unsigned i = 0; i < W2; i++) t[i] = '{g: s2_q.gg[i], p: s2_q.pp[i]};
    for (int unsigned k = 0; k + 1 < LEVELS; k++) begin
      l = LEVELS - 2 - k;
      for (int unsigned i = 0; i < W2; i++)
        if ((((i + 1) % (2 << l)) == (1 << l)) && ((i + 1) >= 3 * (1 << l)))
          t[i] = bk_pg(t[i].g, t[i].p, t[i - (1 << l)].g, t[i - (1 << l)].p);
    end
    c    = '0;
    c[0] = 1'b1;
    for (int unsigned i = 1; i < W2; i++) c[i] = t[i - 1].g;
    d        = s2_q.p ^ c;
    s3_d     = '0;
    s3_d.b   = d[WIDTH-1:0];
    s3_d.err = d[W2-1] | d[WIDTH];
    s3_d.tag = s2_q.tag;
  end

  bk_pipe_stage #(.W($bits(s1_t))) u_st1 (
    .clk(clk), .rst_n(rst_n),
    .valid_i(in_valid), .ready_o(in_ready), .data_i(s1_d),
    .valid_o(v1), .ready_i(r2), .data_o(s1_q)
  );

  bk_pipe_stage #(.W($bits(s2_t))) u_st2 (
    .clk(clk), .rst_n(rst_n),
    .valid_i(v1), .ready_o(r2), .data_i(s2_d),
    .valid_o(v2), .ready_i(r3), .data_o(s2_q)
  );

  bk_pipe_stage #(.W($bits(s3_t))) u_st3 (
    .clk(clk), .rst_n(rst_n),
    .valid_i(v2), .ready_o(r3), .data_i(s3_d),
    .valid_o(out_valid), .ready_i(out_ready), .data_o(s3_q)
  );

  assign out_b   = s3_q.b;
  assign out_err = s3_q.err;
  assign out_tag = s3_q.tag;

endmodule
